// File: rtl/aes_axi_stream_master_pkg.sv
// Shared constants and FSM encoding for the AES AXI-Stream output path.
// Block/word geometry mirrors the slave-side assembly so blocks round-trip unchanged.
package aes_axi_stream_master_pkg;

    localparam int WORD_S = 32;
    localparam int BLK_S  = 128;
    localparam int NB     = BLK_S / WORD_S;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_SEND  = 1'b1
    } state_e;

    // True when the word counter addresses the final beat of a block.
    function automatic logic is_final_word(input logic [1:0] cnt);
        return (cnt == 2'(NB - 1));
    endfunction

    // True when the word counter addresses the beat just before the final one.
    function automatic logic is_penultimate_word(input logic [1:0] cnt);
        return (cnt == 2'(NB - 2));
    endfunction

endpackage

// File: rtl/aes_axi_stream_master_fifo.sv
// First-word-fall-through block FIFO holding {last flag, AES block} entries.
// A write is accepted at full when a read frees a slot on the same cycle.
module aes_axi_stream_master_fifo
    import aes_axi_stream_master_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = BLK_S + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_valid_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ready_o,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          almost_full_o,
    output logic          empty_o
);

    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW + 1)'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, almost_full_q, empty_q;
    logic          wr_fire_s, rd_fire_s;

    assign rd_valid_o    = !empty_q;
    assign rd_fire_s     = rd_valid_o && rd_ready_i;
    assign wr_ready_o    = !full_q || rd_fire_s;
    assign wr_fire_s     = wr_valid_i && wr_ready_o;
    assign rd_data_o     = mem_q[rd_ptr_q];
    assign full_o        = full_q;
    assign almost_full_o = almost_full_q;
    assign empty_o       = empty_q;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {(AW + 1){1'b0}};
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= (count_d == FULL_CNT);
            almost_full_q <= (count_d >= AFULL_CNT);
            empty_q       <= (count_d == {(AW + 1){1'b0}});
        end
    end

    // Storage array; stale contents are never presented because empty gates the read side.
    always_ff @(posedge clk_i) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/aes_axi_stream_master.sv
// AES output FIFO plus 128-bit to 4x32-bit AXI-Stream serializer with tlast/done signalling.
// Optional AES_AXIS_MASTER_BLK_CNT_EN adds a per-packet transmitted-block counter output.
module aes_axi_stream_master
    import aes_axi_stream_master_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_SIZE            = 16,
    parameter int FIFO_ADDR_WIDTH      = 4,
    parameter int FIFO_DATA_WIDTH      = 128
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                aes_controller_out_fifo_w_e,
    input  logic                                aes_controller_out_blk_last,
    input  logic [FIFO_DATA_WIDTH-1:0]          out_fifo_wdata,
    output logic                                out_fifo_write_tready,
    output logic                                out_fifo_almost_full,
    output logic                                out_fifo_full,
    output logic                                out_fifo_empty,
`ifdef AES_AXIS_MASTER_BLK_CNT_EN
    output logic [15:0]                         axis_master_blk_cnt,
`endif
    output logic                                axis_master_done
);

    localparam int ENTRY_W = FIFO_DATA_WIDTH + 1;

    state_e                     state_q;
    logic [1:0]                 word_cnt_q;
    logic [FIFO_DATA_WIDTH-1:0] shreg_q;
    logic                       last_q;
    logic                       tvalid_q;
    logic                       tlast_q;
    logic                       done_q;

    logic                       rd_valid_s;
    logic                       rd_ready_s;
    logic [ENTRY_W-1:0]         rd_entry_s;
    logic [ENTRY_W-1:0]         wr_entry_s;
    logic                       hs_s;
    logic                       final_hs_s;

    assign wr_entry_s = {aes_controller_out_blk_last, out_fifo_wdata};
    assign rd_ready_s = (state_q == ST_FETCH);
    assign hs_s       = tvalid_q && m00_axis_tready;
    assign final_hs_s = hs_s && is_final_word(word_cnt_q);

    aes_axi_stream_master_fifo #(
        .DEPTH (FIFO_SIZE),
        .AW    (FIFO_ADDR_WIDTH),
        .DW    (ENTRY_W)
    ) u_out_fifo (
        .clk_i         (m00_axis_aclk),
        .rst_ni        (m00_axis_aresetn),
        .wr_valid_i    (aes_controller_out_fifo_w_e),
        .wr_data_i     (wr_entry_s),
        .wr_ready_o    (out_fifo_write_tready),
        .rd_valid_o    (rd_valid_s),
        .rd_ready_i    (rd_ready_s),
        .rd_data_o     (rd_entry_s),
        .full_o        (out_fifo_full),
        .almost_full_o (out_fifo_almost_full),
        .empty_o       (out_fifo_empty)
    );

    assign m00_axis_tvalid  = tvalid_q;
    assign m00_axis_tdata   = shreg_q[C_M_AXIS_TDATA_WIDTH-1:0];
    assign m00_axis_tlast   = tlast_q;
    assign m00_axis_tstrb   = {(C_M_AXIS_TDATA_WIDTH / 8){1'b1}};
    assign axis_master_done = done_q;

    // Fetch/send FSM; tdata is the low word of the shift register, so it is registered too.
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q    <= ST_FETCH;
            word_cnt_q <= 2'd0;
            shreg_q    <= {FIFO_DATA_WIDTH{1'b0}};
            last_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= final_hs_s && last_q;
            case (state_q)
                ST_FETCH: begin
                    if (rd_valid_s) begin
                        shreg_q    <= rd_entry_s[FIFO_DATA_WIDTH-1:0];
                        last_q     <= rd_entry_s[FIFO_DATA_WIDTH];
                        word_cnt_q <= 2'd0;
                        tvalid_q   <= 1'b1;
                        tlast_q    <= 1'b0;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        shreg_q    <= shreg_q >> C_M_AXIS_TDATA_WIDTH;
                        word_cnt_q <= word_cnt_q + 2'd1;
                        if (is_final_word(word_cnt_q)) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state_q  <= ST_FETCH;
                        end else begin
                            tlast_q <= last_q && is_penultimate_word(word_cnt_q);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_FETCH;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_AXIS_MASTER_BLK_CNT_EN
    logic [15:0] blk_cnt_q;

    // Blocks fully sent in the current packet; cleared once the done pulse is seen.
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            blk_cnt_q <= 16'd0;
        end else if (done_q) begin
            blk_cnt_q <= 16'd0;
        end else if (final_hs_s && (blk_cnt_q != 16'hFFFF)) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end else begin
            blk_cnt_q <= blk_cnt_q;
        end
    end

    assign axis_master_blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_axi_stream_master.sv
// Self-checking bench: randomized blocks scored against a queue model of the expected beat stream.
module tb_aes_axi_stream_master;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         tready;
    logic         w_e;
    logic         blk_last;
    logic [127:0] wdata;
    logic         tvalid;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic         write_tready;
    logic         almost_full;
    logic         full;
    logic         empty;
    logic         done;
`ifdef AES_AXIS_MASTER_BLK_CNT_EN
    logic [15:0]  blk_cnt;
`endif

    aes_axi_stream_master dut (
        .m00_axis_aclk               (clk),
        .m00_axis_aresetn            (aresetn),
        .m00_axis_tvalid             (tvalid),
        .m00_axis_tready             (tready),
        .m00_axis_tdata              (tdata),
        .m00_axis_tstrb              (tstrb),
        .m00_axis_tlast              (tlast),
        .aes_controller_out_fifo_w_e (w_e),
        .aes_controller_out_blk_last (blk_last),
        .out_fifo_wdata              (wdata),
        .out_fifo_write_tready       (write_tready),
        .out_fifo_almost_full        (almost_full),
        .out_fifo_full               (full),
        .out_fifo_empty              (empty),
`ifdef AES_AXIS_MASTER_BLK_CNT_EN
        .axis_master_blk_cnt         (blk_cnt),
`endif
        .axis_master_done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [1:0]  idx;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    done_seen  = 0;
    int    beats_seen = 0;
    logic  exp_done_next = 1'b0;
    logic  prev_stall    = 1'b0;
    logic [31:0] stall_d;
    logic        stall_l;
    logic [15:0] exp_blk = 16'd0;

    // Stream monitor: scoreboard, stall stability, done timing, block count.
    always @(negedge clk) begin : monitor
        beat_t b;
        logic  cur_done;
        cur_done = exp_done_next;
        n_checks++;
        if (done !== cur_done) begin
            n_fail++;
            $display("FAIL done_timing: got %b want %b at %0t", done, cur_done, $time);
        end
        if (done === 1'b1) done_seen++;
`ifdef AES_AXIS_MASTER_BLK_CNT_EN
        n_checks++;
        if (blk_cnt !== exp_blk) begin
            n_fail++;
            $display("FAIL blk_cnt: got %0d want %0d at %0t", blk_cnt, exp_blk, $time);
        end
`endif
        if (prev_stall) begin
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== stall_d || tlast !== stall_l) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         tvalid, tdata, tlast, stall_d, stall_l);
            end
        end
        exp_done_next = 1'b0;
        if (cur_done) exp_blk = 16'd0;
        if (aresetn === 1'b1 && tvalid === 1'b1 && tready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got d=%h l=%b want no beat", tdata, tlast);
            end else begin
                b = exp_q.pop_front();
                beats_seen++;
                if (tdata !== b.d || tlast !== b.l) begin
                    n_fail++;
                    $display("FAIL beat_data: got d=%h l=%b want d=%h l=%b", tdata, tlast, b.d, b.l);
                end
                if (b.l) exp_done_next = 1'b1;
                if (b.idx == 2'd3 && exp_blk != 16'hFFFF) exp_blk = exp_blk + 16'd1;
            end
        end
        prev_stall = (aresetn === 1'b1) && (tvalid === 1'b1) && (tready !== 1'b1);
        stall_d    = tdata;
        stall_l    = tlast;
        if (aresetn !== 1'b1) begin
            exp_blk       = 16'd0;
            exp_done_next = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic [127:0] b, input logic last, input logic exp_acc);
        w_e      = 1'b1;
        wdata    = b;
        blk_last = last;
        @(negedge clk);
        n_checks++;
        if (write_tready !== exp_acc) begin
            n_fail++;
            $display("FAIL write_tready: got %b want %b", write_tready, exp_acc);
        end
        if (exp_acc) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{d: b[32*i +: 32], l: (i == 3) && last, idx: 2'(i)});
            end
        end
        @(posedge clk);
        #1;
        w_e = 1'b0;
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tvalid === 1'b1) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending want 0", exp_q.size());
        end
        repeat (2) step();
    endtask

    task automatic check_count(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'h0 || done !== 1'b0 ||
            empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
            write_tready !== 1'b1 || tstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b l=%b d=%h dn=%b e=%b f=%b af=%b wr=%b s=%h want 0 0 0 0 1 0 0 1 f",
                     tvalid, tlast, tdata, done, empty, full, almost_full, write_tready, tstrb);
        end
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single_block();
        int d0 = done_seen;
        int b0 = beats_seen;
        tready = 1'b1;
        push_block(128'h33333333_22222222_11111111_00000000, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got tvalid=%b want 0", tvalid);
        end
        @(negedge clk);
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h00000000) begin
            n_fail++;
            $display("FAIL latency_first: got v=%b d=%h want v=1 d=00000000", tvalid, tdata);
        end
        @(posedge clk);
        #1;
        wait_drain(40);
        check_count("single_beats", beats_seen - b0, 4);
        check_count("single_done", done_seen - d0, 1);
    endtask

    task automatic test_multi_block();
        int d0 = done_seen;
        int low = 0;
        int started = 0;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) push_block(rand_blk(), i == 2, 1'b1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tvalid === 1'b1) started = 1;
            else if (started != 0 && exp_q.size() != 0) low++;
            if (started != 0 && exp_q.size() == 0) break;
        end
        @(posedge clk);
        #1;
        wait_drain(60);
        check_count("multi_bubbles", low, 2);
        check_count("multi_done", done_seen - d0, 1);
    endtask

    task automatic test_backpressure();
        int d0 = done_seen;
        int b0 = beats_seen;
        int lasts = 0;
        int n = 0;
        logic lf;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    lf = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (lf) lasts++;
                    push_block(rand_blk(), lf, 1'b1);
                end
            end
            begin
                repeat (8) begin
                    tready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        while ((exp_q.size() != 0 || tvalid === 1'b1) && n < 400) begin
            tready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        tready = 1'b1;
        wait_drain(20);
        check_count("bp_beats", beats_seen - b0, 24);
        check_count("bp_done", done_seen - d0, lasts);
    endtask

    task automatic test_fill_full();
        int d0 = done_seen;
        int b0 = beats_seen;
        tready = 1'b0;
        // One block sits in the serializer, so 17 writes are taken before the FIFO is full.
        for (int i = 0; i < 18; i++) push_block(rand_blk(), i >= 16, i < 17);
        @(negedge clk);
        n_checks++;
        if (full !== 1'b1 || write_tready !== 1'b0 || almost_full !== 1'b1 ||
            empty !== 1'b0 || tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_flags: got f=%b wr=%b af=%b e=%b v=%b want 1 0 1 0 1",
                     full, write_tready, almost_full, empty, tvalid);
        end
        @(posedge clk);
        #1;
        tready = 1'b1;
        wait_drain(400);
        @(negedge clk);
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drained: got e=%b f=%b want e=1 f=0", empty, full);
        end
        @(posedge clk);
        #1;
        check_count("fill_beats", beats_seen - b0, 68);
        check_count("fill_done", done_seen - d0, 1);
    endtask

    task automatic test_reset_mid_block();
        int b0 = beats_seen;
        int d0;
        int n = 0;
        tready = 1'b1;
        push_block(rand_blk(), 1'b1, 1'b1);
        while (beats_seen < b0 + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_count("mid_reach_beat2", (beats_seen >= b0 + 2) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        aresetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'h0 || empty !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b l=%b d=%h e=%b dn=%b want 0 0 0 1 0",
                     tvalid, tlast, tdata, empty, done);
        end
        exp_q.delete();
        d0 = done_seen;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (4) step();
        check_count("mid_no_done", done_seen - d0, 0);
        push_block(rand_blk(), 1'b1, 1'b1);
        wait_drain(40);
        check_count("mid_fresh_done", done_seen - d0, 1);
    endtask

    task automatic test_back_to_back();
        int d0 = done_seen;
        tready = 1'b1;
        push_block(rand_blk(), 1'b1, 1'b1);
        push_block(rand_blk(), 1'b1, 1'b1);
        wait_drain(60);
        check_count("b2b_done", done_seen - d0, 2);
    endtask

    task automatic test_long_packet();
        int d0 = done_seen;
        tready = 1'b1;
        for (int i = 0; i < 5; i++) push_block(rand_blk(), i == 4, 1'b1);
        wait_drain(80);
        check_count("long_done", done_seen - d0, 1);
    endtask

    initial begin
        aresetn  = 1'b0;
        tready   = 1'b0;
        w_e      = 1'b0;
        blk_last = 1'b0;
        wdata    = 128'h0;
        test_reset();
        test_single_block();
        test_multi_block();
        test_backpressure();
        test_fill_full();
        test_reset_mid_block();
        test_back_to_back();
        test_long_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
